// File: rtl/fpr_cdb_arbiter.sv
// Round-robin arbiter for the floating-point common data bus: grants one
// requesting unit per cycle and broadcasts that unit's result one cycle later.
module fpr_cdb_arbiter #(
   parameter int N_REQ     = 4,
   parameter int ROB_WIDTH = 6,
   parameter int DATA_W    = 32
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [N_REQ-1:0]              req_valid,
   output logic [N_REQ-1:0]              req_ready,
   input  logic [N_REQ*ROB_WIDTH-1:0]    result_tag,
   input  logic [N_REQ*DATA_W-1:0]       result_data,
   output logic                          fpr_cdb_valid,
   output logic [ROB_WIDTH-1:0]          fpr_cdb_tag,
   output logic [DATA_W-1:0]             fpr_cdb_data
);

   localparam int PTR_W = $clog2(N_REQ);

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] sel_p1;
   logic             vld_p1;
   logic             gnt_any_p0;
   logic [PTR_W-1:0] gnt_idx_p0;

   // Modulo increment so non-power-of-two N_REQ wraps to zero correctly.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] g);
      if (g == PTR_W'(N_REQ - 1))
         return '0;
      return g + 1'b1;
   endfunction

   // Stage p0: combinational grant, scanning from ptr upward with wrap.
   always_comb begin
      int idx;
      idx        = 0;
      gnt_any_p0 = 1'b0;
      gnt_idx_p0 = '0;
      req_ready  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N_REQ)
            idx = idx - N_REQ;
         if (!gnt_any_p0 && req_valid[idx]) begin
            gnt_any_p0 = 1'b1;
            gnt_idx_p0 = PTR_W'(idx);
         end
      end
      if (!reset_n)
         gnt_any_p0 = 1'b0;
      for (int i = 0; i < N_REQ; i++)
         req_ready[i] = gnt_any_p0 && (gnt_idx_p0 == PTR_W'(i));
   end

   // Stage p1: registered grant index and broadcast-valid.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ptr    <= '0;
         sel_p1 <= '0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= gnt_any_p0;
         if (gnt_any_p0) begin
            sel_p1 <= gnt_idx_p0;
            ptr    <= next_ptr(gnt_idx_p0);
         end
      end
   end

   always_comb begin
      fpr_cdb_valid = vld_p1;
      fpr_cdb_tag   = '0;
      fpr_cdb_data  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (sel_p1 == PTR_W'(i)) begin
            fpr_cdb_tag  = result_tag[i*ROB_WIDTH +: ROB_WIDTH];
            fpr_cdb_data = result_data[i*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: tb/tb_fpr_cdb_arbiter.sv
// Bench for fpr_cdb_arbiter: a 4-unit instance driven from a vector table with a
// broadcast scoreboard, and a 3-unit instance for pointer skip and wrap.
module tb_fpr_cdb_arbiter;

   logic clk = 1'b0;
   logic reset_n;

   logic [3:0]       req_valid;
   logic [3:0]       req_ready;
   logic [3:0][5:0]  res_tag;
   logic [3:0][31:0] res_data;
   logic             cdb_valid;
   logic [5:0]       cdb_tag;
   logic [31:0]      cdb_data;

   logic [2:0]       req3_valid;
   logic [2:0]       req3_ready;
   logic [2:0][5:0]  res3_tag;
   logic [2:0][31:0] res3_data;
   logic             cdb3_valid;
   logic [5:0]       cdb3_tag;
   logic [31:0]      cdb3_data;

   always #5 clk = ~clk;

   fpr_cdb_arbiter #(.N_REQ(4), .ROB_WIDTH(6), .DATA_W(32)) dut4 (
      .clk           (clk),
      .reset_n       (reset_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .result_tag    (res_tag),
      .result_data   (res_data),
      .fpr_cdb_valid (cdb_valid),
      .fpr_cdb_tag   (cdb_tag),
      .fpr_cdb_data  (cdb_data)
   );

   fpr_cdb_arbiter #(.N_REQ(3), .ROB_WIDTH(6), .DATA_W(32)) dut3 (
      .clk           (clk),
      .reset_n       (reset_n),
      .req_valid     (req3_valid),
      .req_ready     (req3_ready),
      .result_tag    (res3_tag),
      .result_data   (res3_data),
      .fpr_cdb_valid (cdb3_valid),
      .fpr_cdb_tag   (cdb3_tag),
      .fpr_cdb_data  (cdb3_data)
   );

   typedef struct packed {
      logic       rstn;
      logic [3:0] v;
      logic [3:0] rdy;
   } vec_t;

   typedef struct packed {
      logic        v;
      logic [5:0]  tag;
      logic [31:0] data;
   } exp_t;

   vec_t       tbl[17];
   exp_t       exp_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   logic [3:0] rdy_q;
   logic [5:0] next_tag[4];
   logic [31:0] next_data[4];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got %0h want %0h", name, cyc, got, want);
      end
   endtask

   // One cycle on the 4-unit instance; units reload their result on the edge they were granted.
   task automatic step(input logic rstn, input logic [3:0] v, input logic [3:0] rdy);
      exp_t e;
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         if (rdy_q[i]) begin
            res_tag[i]   = next_tag[i];
            res_data[i]  = next_data[i];
            next_tag[i]  = next_tag[i] + 6'd1;
            next_data[i] = next_data[i] + 32'h0080_0000;
         end
      end
      #1;
      reset_n   = rstn;
      req_valid = v;
      #1;
      cyc++;
      check("ready", 64'(req_ready), 64'(rdy));
      rdy_q = req_ready;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard @cycle %0d: got empty queue want entry", cyc);
      end else begin
         e = exp_q.pop_front();
         check("cdb_valid", 64'(cdb_valid), 64'(e.v));
         if (e.v) begin
            check("cdb_tag", 64'(cdb_tag), 64'(e.tag));
            check("cdb_data", 64'(cdb_data), 64'(e.data));
         end
      end
      e = '0;
      for (int i = 0; i < 4; i++) begin
         if (rdy[i]) begin
            e.v    = 1'b1;
            e.tag  = next_tag[i];
            e.data = next_data[i];
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic step3(input logic [2:0] v, input logic [2:0] rdy, input logic bv, input logic [5:0] tag);
      @(posedge clk);
      #1;
      req3_valid = v;
      #1;
      cyc++;
      check("ready3", 64'(req3_ready), 64'(rdy));
      check("cdb3_valid", 64'(cdb3_valid), 64'(bv));
      if (bv)
         check("cdb3_tag", 64'(cdb3_tag), 64'(tag));
   endtask

   initial begin
      reset_n    = 1'b0;
      req_valid  = '0;
      req3_valid = '0;
      rdy_q      = '0;
      res_tag    = '0;
      res_data   = '0;
      for (int i = 0; i < 3; i++) begin
         res3_tag[i]  = 6'(10 + i);
         res3_data[i] = 32'h0;
      end
      for (int i = 0; i < 4; i++) begin
         next_tag[i]  = 6'(1 + 12 * i);
         next_data[i] = 32'h4100_0000 + 32'(i) * 32'h0100_0000;
      end

      // reset/idle, round-robin from reset, gap, pointer hold, mid-stream reset
      tbl[0]  = '{1'b0, 4'b1111, 4'b0000};
      tbl[1]  = '{1'b0, 4'b1111, 4'b0000};
      tbl[2]  = '{1'b0, 4'b1111, 4'b0000};
      tbl[3]  = '{1'b1, 4'b1111, 4'b0001};
      tbl[4]  = '{1'b1, 4'b1111, 4'b0010};
      tbl[5]  = '{1'b1, 4'b1111, 4'b0100};
      tbl[6]  = '{1'b1, 4'b1111, 4'b1000};
      tbl[7]  = '{1'b1, 4'b1111, 4'b0001};
      tbl[8]  = '{1'b1, 4'b1111, 4'b0010};
      tbl[9]  = '{1'b1, 4'b0000, 4'b0000};
      tbl[10] = '{1'b1, 4'b0000, 4'b0000};
      tbl[11] = '{1'b1, 4'b1001, 4'b1000};
      tbl[12] = '{1'b1, 4'b1001, 4'b0001};
      tbl[13] = '{1'b1, 4'b1111, 4'b0010};
      tbl[14] = '{1'b0, 4'b1111, 4'b0000};
      tbl[15] = '{1'b1, 4'b1111, 4'b0001};
      tbl[16] = '{1'b1, 4'b0000, 4'b0000};

      repeat (2) @(posedge clk);
      exp_q.push_back('0);

      for (int n = 0; n < 17; n++)
         step(tbl[n].rstn, tbl[n].v, tbl[n].rdy);

      // lone requester, back-to-back: tags 5..8, data 1.0, 2.0, 4.0, 8.0
      next_tag[2]  = 6'd5;
      next_data[2] = 32'h3F80_0000;
      repeat (4) step(1'b1, 4'b0100, 4'b0100);
      step(1'b1, 4'b0000, 4'b0000);

      // withdrawn request: unit 1 loses to unit 0, drops, ptr lands on 1
      step(1'b1, 4'b1000, 4'b1000);
      step(1'b1, 4'b0011, 4'b0001);
      step(1'b1, 4'b0101, 4'b0100);
      step(1'b1, 4'b0000, 4'b0000);

      // N_REQ=3: skip of idle unit 1 and wrap 2 -> 0
      step3(3'b001, 3'b001, 1'b0, 6'd0);
      step3(3'b101, 3'b100, 1'b1, 6'd10);
      step3(3'b101, 3'b001, 1'b1, 6'd12);
      step3(3'b101, 3'b100, 1'b1, 6'd10);
      step3(3'b000, 3'b000, 1'b1, 6'd12);
      step3(3'b000, 3'b000, 1'b0, 6'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fpr_cdb_arbiter.md
# fpr_cdb_arbiter

Round-robin arbiter and broadcaster for the floating-point common data bus. Each FPR-writing execution unit raises a request through its `req_if`. The arbiter grants exactly one per cycle and, one cycle later, drives that unit's registered result onto `fpr_cdb` for the ROB, FPR file and every reservation station. It is the responder side of the units' `fpr_cdb_req` handshake.

## Interface
- `N_REQ`, default 4: number of requesting units; must be 2 to 8.
- Tag width is `ROB_WIDTH` from `common.vh`. Data width is 32. Both are carried in `cdb_t {valid, tag, data}`.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset_n`  input  1  reset, synchronous and active-low.
- `req[N_REQ-1:0]`  `req_if` (responder side)  —  `req[i].valid` is an input; `req[i].ready` is an output (grant).
- `result[N_REQ-1:0]`  input  `cdb_t`  per-unit result register. The unit loads it on the edge where its request was granted; only `tag` and `data` are used.
- `fpr_cdb`  output  `cdb_t`  broadcast bus: `valid`, `tag` (ROB_WIDTH bits), `data` (32 bits).

## Operation
- State:
  - `ptr`: priority pointer, `$clog2(N_REQ)` bits.
  - `sel`: registered grant index.
  - `bcast`: registered broadcast-valid flag.
- Grant (combinational, same cycle):
  - Scan indices `ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1`.
  - The first `i` with `req[i].valid=1` gets `req[i].ready=1`; every other `ready` is 0.
  - If no request is valid, all `ready` are 0.
  - `ready[i]` may depend on the current `req[*].valid` (no registered ready). Units compute `valid` without looking at `ready`, so there is no loop.
- Update on each edge while `reset_n=1`:
  - If a grant `g` occurred: `sel<=g`, `bcast<=1`, and `ptr<=(g+1) mod N_REQ`.
  - If no grant occurred: `bcast<=0`, and `ptr` and `sel` hold.
- Broadcast (combinational from registers):
  - `fpr_cdb.valid=bcast`.
  - `fpr_cdb.tag=result[sel].tag` and `fpr_cdb.data=result[sel].data` when `bcast=1`.
  - Tag and data are don't-care (x allowed) when `bcast=0`. Consumers qualify with `valid` via `tag_match`.
- Pointer wrap: the increment is modulo `N_REQ`, which also covers non-power-of-two `N_REQ` (e.g. 3: 2→0).
- Fairness: a unit that holds `valid` continuously is granted within `N_REQ` cycles. A lone requester is granted every cycle (back-to-back broadcasts).
- A requester may drop `valid` in a cycle without being granted. No grant is remembered for it, and `ptr` is unaffected.

## Timing
- Reset (`reset_n=0` at an edge): `ptr<=0`, `sel<=0`, `bcast<=0`.
- While `reset_n=0`, all `ready` are forced to 0.
- The cycle after reset is released, `fpr_cdb.valid=0`.
- Reset asserted mid-stream: a grant given in the same cycle is discarded and `bcast=0` next cycle. Units clear themselves on their own reset, so no broadcast is lost that matters.
- Latency: the grant is issued in cycle t. In cycle t+1 the unit's `result` register holds the value and `fpr_cdb` carries it with `valid=1`. Fixed 1-cycle latency, throughput 1 per cycle.
- `result[sel]` must stay stable through cycle t+1. A unit reloads its result register only when granted again; if so, this happens at the end of t+1 at the earliest, so it is safe.
- No combinational path from `result` to `ready`. The `valid`→`ready` path is combinational.

## Test plan
- **Reset / idle:** hold `reset_n=0` 3 cycles with `req[0..3].valid=1`. Required: all `ready=0` and `fpr_cdb.valid=0` throughout, and for 1 cycle after release. In the first free cycle `ready[0]=1`.
- **Single requester, back-to-back:** only `req[2].valid=1` for 4 cycles, with results loaded as tags 5, 6, 7, 8 and data `0x3F800000`, … on each grant. Required: `ready[2]=1` every cycle; `fpr_cdb` shows `{1,5,0x3F800000}`, then 6, 7, 8 on consecutive cycles, each one cycle after its grant.
- **Round-robin:** all four `valid=1` continuously from reset. Required: grant order 0, 1, 2, 3, 0, …; exactly one `ready` high per cycle; `fpr_cdb.tag` each cycle equals the previous cycle's granted unit's tag.
- **Pointer skip and wrap, `N_REQ=3`:** `valid={1,0,1}` (units 0 and 2) with `ptr` at 1. Required: unit 2 granted, then `ptr=0`, then unit 0 granted, then `ptr=1`.
- **Withdrawn request:** `req[1].valid=1` for one cycle while unit 0 wins, then drops. Required: unit 1 is never granted and no broadcast carries its tag; after the unit-0 grant `ptr=1`.
- **Gap:** grant in cycle t, no requests in t+1. Required: `fpr_cdb.valid=1` in t+1 and 0 in t+2; `sel` is unchanged in t+2.
